// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, FSM encoding and op helpers for the serial ALU
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Subtract and both compares run as a + ~b + 1.
    function automatic logic op_inverts_b(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_LT) || (op == OP_EQ);
    endfunction

    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || op_inverts_b(op);
    endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// rtl/alu_nibble_slice.sv - combinational 4-bit ALU slice with carry in/out
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [2:0]          op,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] r,
    output logic                cout
);

    logic [NIBBLE_W-1:0] b_eff;
    logic [NIBBLE_W:0]   sum;

    assign b_eff = op_inverts_b(op) ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin};

    always_comb begin
        r    = '0;
        cout = 1'b0;
        case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: {cout, r} = sum;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - W-bit ALU built by time-multiplexing one 4-bit slice, LSB nibble first
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              op,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    result,
    output logic                    zero,
    output logic                    overflow,
    output logic                    carry,
    output logic                    size
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    logic [1:0]          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [2:0]          op_q;
    logic [W-1:0]        a_sh_q;
    logic [W-1:0]        b_sh_q;
    logic                cin_q;

    logic [NIBBLE_W-1:0] r_nib;
    logic                cout_nib;

    // Operands shift right each RUN cycle so the slice always sees the current nibble at [3:0].
    alu_nibble_slice u_slice (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .op   (op_q),
        .cin  (cin_q),
        .r    (r_nib),
        .cout (cout_nib)
    );

    logic [W-1:0] final_result;
    logic         b_eff_msb;
    logic         arith;
    logic         final_zero;
    logic         final_ovf;

    // Only meaningful on the last nibble, when every lower nibble is already in result.
    assign final_result = {r_nib, result[W-NIBBLE_W-1:0]};
    assign b_eff_msb    = b_sh_q[NIBBLE_W-1] ^ op_inverts_b(op_q);
    assign arith        = op_is_arith(op_q);
    assign final_zero   = (final_result == '0);
    assign final_ovf    = arith && (a_sh_q[NIBBLE_W-1] == b_eff_msb)
                                && (r_nib[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            op_q      <= OP_ADD;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cin_q     <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            size      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        idx_q    <= '0;
                        cin_q    <= op_inverts_b(op);
                        result   <= '0;
                        in_ready <= 1'b0;
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result[NIBBLE_W*idx_q +: NIBBLE_W] <= r_nib;
                    a_sh_q <= a_sh_q >> NIBBLE_W;
                    b_sh_q <= b_sh_q >> NIBBLE_W;
                    cin_q  <= cout_nib;
                    idx_q  <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        zero      <= final_zero;
                        overflow  <= final_ovf;
                        carry     <= arith & cout_nib;
                        size      <= (op_q == OP_LT) ? (r_nib[NIBBLE_W-1] ^ final_ovf)
                                   : (op_q == OP_EQ) ? final_zero : 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - directed and random checks of alu_serial_seq against an arithmetic model
module tb_alu_serial_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, overflow, carry, size;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow),
        .carry     (carry),
        .size      (size)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         c;
        logic         s;
    } exp_t;

    function automatic exp_t model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int sx, sy, sr, ux, uy, ur;
        sx = $signed(x);
        sy = $signed(y);
        ux = int'(x);
        uy = int'(y);
        e  = '0;
        case (f)
            3'd0: begin
                ur    = ux + uy;
                sr    = sx + sy;
                e.res = W'(ur);
                e.c   = (ur > 65535);
                e.o   = (sr > 32767) || (sr < -32768);
            end
            3'd1, 3'd6, 3'd7: begin
                ur    = ux - uy;
                sr    = sx - sy;
                e.res = W'(ur);
                e.c   = (ux >= uy);
                e.o   = (sr > 32767) || (sr < -32768);
                if (f == 3'd6) e.s = (sx < sy);
                if (f == 3'd7) e.s = (ux == uy);
            end
            3'd2: e.res = ~x;
            3'd3: e.res = x & y;
            3'd4: e.res = x | y;
            default: e.res = x ^ y;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_flags(input string tag, input exp_t e);
        check({tag, ".result"},   result,         e.res);
        check({tag, ".zero"},     W'(zero),       W'(e.z));
        check({tag, ".overflow"}, W'(overflow),   W'(e.o));
        check({tag, ".carry"},    W'(carry),      W'(e.c));
        check({tag, ".size"},     W'(size),       W'(e.s));
    endtask

    // Issues one request from a negedge and returns with out_valid high (or its bound expired).
    task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        op = f;
        a  = x;
        b  = y;
        @(negedge clk);
        in_valid = 1'b0;
        check("accept.in_ready_low", W'(in_ready), W'(1'b0));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("response.out_valid", W'(out_valid), W'(1'b1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs.in_ready",  W'(in_ready),  W'(1'b1));
        check("hs.out_valid", W'(out_valid), W'(1'b0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        exp_t e;
        e = model(f, x, y);
        issue(f, x, y, lat);
        check({tag, ".latency"}, W'(lat), W'(NIB));
        check_flags(tag, e);
        handshake();
        check({tag, ".held_result"}, result, e.res);
    endtask

    initial begin
        exp_t e;
        exp_t zero_e;
        int   lat;
        logic [W-1:0] held;

        zero_e = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready",  W'(in_ready),  W'(1'b1));
        check("reset.out_valid", W'(out_valid), W'(1'b0));
        check_flags("reset", zero_e);

        run_op("add_ovf",   3'd0, 16'h7FFF, 16'h0001);
        run_op("add_wrap",  3'd0, 16'hFFFF, 16'h0001);
        run_op("sub_neg",   3'd1, 16'h0003, 16'h0005);
        run_op("lt_small",  3'd6, 16'h0003, 16'h0005);
        run_op("lt_ovf",    3'd6, 16'h8000, 16'h0001);
        run_op("eq_same",   3'd7, 16'h1234, 16'h1234);
        run_op("xor",       3'd5, 16'hF0F0, 16'hFFFF);
        run_op("not",       3'd2, 16'h00FF, 16'h1234);

        // Backpressure: response held, concurrent request ignored and not queued.
        e = model(3'd4, 16'hA50F, 16'h0F30);
        issue(3'd4, 16'hA50F, 16'h0F30, lat);
        held = result;
        in_valid = 1'b1;
        op = 3'd0;
        a  = 16'h1111;
        b  = 16'h2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.out_valid", W'(out_valid), W'(1'b1));
            check("bp.in_ready",  W'(in_ready),  W'(1'b0));
            check("bp.result",    result,        held);
        end
        check_flags("bp", e);
        in_valid = 1'b0;
        handshake();
        repeat (2) begin
            @(negedge clk);
            check("bp.no_queue_valid", W'(out_valid), W'(1'b0));
            check("bp.no_queue_ready", W'(in_ready),  W'(1'b1));
        end

        // Reset while the third nibble is the one in flight.
        in_valid = 1'b1;
        op = 3'd0;
        a  = 16'hFFFF;
        b  = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.in_ready",  W'(in_ready),  W'(1'b1));
        check("midrst.out_valid", W'(out_valid), W'(1'b0));
        check_flags("midrst", zero_e);
        run_op("after_rst", 3'd0, 16'h0001, 16'h0001);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]   rf;
            logic [W-1:0] rx, ry;
            rf = 3'($urandom_range(0, 7));
            rx = W'($urandom);
            ry = (i % 8 == 0) ? rx : W'($urandom);
            run_op($sformatf("rand%0d_op%0d", i, rf), rf, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
